// File: rtl/nmr_pkg.sv
// Shared constants, FSM state type and quarter-wave sine table generator
// for the NMR receive demodulator and the quadrature NCO.
package nmr_pkg;

  localparam int unsigned DW        = 16;
  localparam int unsigned PW        = 32;
  localparam int unsigned LUT_AW    = 10;
  localparam int unsigned CW        = 16;
  localparam int unsigned AW        = 48;
  localparam int unsigned LUT_DEPTH = 1 << LUT_AW;
  localparam int unsigned PH_W      = LUT_AW + 2;
  localparam int unsigned AMP       = (1 << (DW - 1)) - 1;

  typedef enum logic [1:0] {IDLE, ACQ, FLUSH} state_t;

  // One quarter-wave entry: round(AMP * sin(2*pi*k / (4*LUT_DEPTH))), k in first quadrant.
  function automatic logic [DW-1:0] lut_entry(input int unsigned k);
    real ang;
    ang = 6.283185307179586 * real'(k) / real'(4 * LUT_DEPTH);
    return DW'($rtoi(real'(AMP) * $sin(ang) + 0.5));
  endfunction

endpackage

// File: rtl/nmr_quad_nco.sv
// Quadrature NCO back end: top phase bits in, registered cos/sin out two
// cycles later, built from a single quarter-wave ROM with quadrant folding.
module nmr_quad_nco
  import nmr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PH_W-1:0]      phase,
  output logic signed [DW-1:0] cos_out,
  output logic signed [DW-1:0] sin_out
);

  logic signed [DW-1:0] rom [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
    localparam logic [DW-1:0] VAL = lut_entry(k);
    assign rom[k] = VAL;
  end

  logic [1:0]           quad_q;
  logic [LUT_AW-1:0]    addr_q;
  logic [LUT_AW-1:0]    mirror;
  logic signed [DW-1:0] s_dir;
  logic signed [DW-1:0] s_mir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quad_q <= '0;
      addr_q <= '0;
    end else begin
      quad_q <= phase[PH_W-1 -: 2];
      addr_q <= phase[LUT_AW-1:0];
    end
  end

  // Mirrored index reaches the quarter-wave peak, which lies one past the table end.
  always_comb begin
    mirror = -addr_q;
    s_dir  = rom[addr_q];
    s_mir  = (addr_q == '0) ? DW'(AMP) : rom[mirror];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cos_out <= '0;
      sin_out <= '0;
    end else begin
      case (quad_q)
        2'd0: begin cos_out <= s_mir;  sin_out <= s_dir;  end
        2'd1: begin cos_out <= -s_dir; sin_out <= s_mir;  end
        2'd2: begin cos_out <= -s_mir; sin_out <= -s_dir; end
        2'd3: begin cos_out <= s_dir;  sin_out <= -s_mir; end
      endcase
    end
  end

endmodule

// File: rtl/nmr_iq_demod.sv
// Coherent I/Q demodulator: mixes accepted ADC samples with the NCO and
// integrates over a programmed sample count, one result pair per acquisition.
module nmr_iq_demod
  import nmr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frq_valid,
  input  logic [PW-1:0]        frq,
  input  logic [PW-1:0]        phase_offset,
  input  logic                 start,
  input  logic [CW-1:0]        n_samples,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in,
  output logic                 busy,
  output logic                 out_valid,
  output logic signed [AW-1:0] i_out,
  output logic signed [AW-1:0] q_out
);

  state_t                 state_q, state_d;
  logic [PW-1:0]          frq_pend, frq_act, phase_acc;
  logic [CW-1:0]          remaining;
  logic                   load, accept, done;
  logic                   d1_valid, d2_valid, m_valid;
  logic signed [DW-1:0]   d1_in, d2_in, cos_v, sin_v;
  logic signed [2*DW-1:0] prod_i, prod_q;
  logic signed [AW-1:0]   acc_i, acc_q;

  nmr_quad_nco u_nco (
    .clk     (clk),
    .rst_n   (rst_n),
    .phase   (phase_acc[PW-1 -: PH_W]),
    .cos_out (cos_v),
    .sin_out (sin_v)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (n_samples != '0)) begin
          load    = 1'b1;
          state_d = ACQ;
        end
      end
      ACQ: begin
        accept = in_valid;
        if (in_valid && (remaining == CW'(1))) state_d = FLUSH;
      end
      FLUSH: begin
        // Result is final once no accepted sample remains in flight.
        if (!d1_valid && !d2_valid && !m_valid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      frq_pend  <= '0;
      frq_act   <= '0;
      phase_acc <= '0;
      remaining <= '0;
      i_out     <= '0;
      q_out     <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != IDLE);
      out_valid <= done;
      if (frq_valid) frq_pend <= frq;
      if (load) begin
        frq_act   <= frq_pend;
        phase_acc <= phase_offset;
        remaining <= n_samples;
      end else if (state_q == ACQ) begin
        phase_acc <= phase_acc + frq_act;
      end
      if (accept) remaining <= remaining - CW'(1);
      if (done) begin
        i_out <= acc_i;
        q_out <= acc_q;
      end
    end
  end

  // Sample delay line aligned to the NCO, then multiply and accumulate stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_valid <= 1'b0;
      d2_valid <= 1'b0;
      m_valid  <= 1'b0;
      d1_in    <= '0;
      d2_in    <= '0;
      prod_i   <= '0;
      prod_q   <= '0;
      acc_i    <= '0;
      acc_q    <= '0;
    end else begin
      d1_valid <= accept;
      d1_in    <= in;
      d2_valid <= d1_valid;
      d2_in    <= d1_in;
      m_valid  <= d2_valid;
      prod_i   <= (2*DW)'(d2_in) * (2*DW)'(cos_v);
      prod_q   <= (2*DW)'(d2_in) * (2*DW)'(sin_v);
      if (load) begin
        acc_i <= '0;
        acc_q <= '0;
      end else if (m_valid) begin
        acc_i <= acc_i + AW'(prod_i);
        acc_q <= acc_q + AW'(prod_q);
      end
    end
  end

endmodule

// File: tb/tb_nmr_iq_demod.sv
// Bench for nmr_iq_demod: directed vector table, hand-written corner
// sequences and random acquisitions against an exact-phase I/Q model.
module tb_nmr_iq_demod;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               frq_valid, start, in_valid;
  logic [31:0]        frq, phase_offset;
  logic [15:0]        n_samples;
  logic signed [15:0] in_s;
  logic               busy, out_valid;
  logic signed [47:0] i_out, q_out;

  int n_cmp  = 0;
  int n_fail = 0;
  int pat[$];

  typedef struct {
    string       name;
    logic [31:0] f;
    logic [31:0] off;
    logic [15:0] n;
    int          gap;
    int          p0, p1, p2, p3;
    bit          has_exp;
    longint      ei, eq;
  } vec_t;

  vec_t vecs[6];

  nmr_iq_demod dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frq_valid    (frq_valid),
    .frq          (frq),
    .phase_offset (phase_offset),
    .start        (start),
    .n_samples    (n_samples),
    .in_valid     (in_valid),
    .in           (in_s),
    .busy         (busy),
    .out_valid    (out_valid),
    .i_out        (i_out),
    .q_out        (q_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Ideal quadrature reference at 12-bit phase resolution, rounded half away from zero.
  function automatic longint nco(input logic [31:0] ph, input bit want_sin);
    real a, v;
    a = 6.283185307179586 * real'(ph[31:20]) / 4096.0;
    v = 32767.0 * (want_sin ? $sin(a) : $cos(a));
    if (v >= 0.0) return longint'($rtoi(v + 0.5));
    else          return -longint'($rtoi(0.5 - v));
  endfunction

  function automatic int rnd_fs();
    case ($urandom_range(0, 3))
      0:       return 32767;
      1:       return -32767;
      default: return int'($urandom_range(0, 65534)) - 32767;
    endcase
  endfunction

  // One acquisition: drives stimulus, tracks the model sums and checks the result.
  task automatic run_acq(input string name, input logic [31:0] f, input logic [31:0] off,
                         input logic [15:0] n, input int gap, input bit poke, input bit load_f,
                         input bit has_exp, input longint exp_i, input longint exp_q);
    longint      mi = 0, mq = 0, gi = 0, gq = 0;
    int          acc = 0, c = 0, last_c = -1, ov_c = -1, busy_err = 0, bound, val;
    bit          v;
    logic [31:0] ph;
    if (load_f) begin
      frq_valid = 1'b1;
      frq       = f;
      @(posedge clk); #1;
      frq_valid = 1'b0;
      frq       = $urandom;
    end
    start        = 1'b1;
    n_samples    = n;
    phase_offset = off;
    in_valid     = 1'b0;
    bound        = int'(n) * 3 + 40;
    ph           = off;
    while (ov_c < 0 && c < bound) begin
      @(posedge clk); #1;
      c++;
      if (busy !== ((last_c < 0) || (c < last_c + 5))) busy_err++;
      if (out_valid) begin
        ov_c = c;
        gi   = i_out;
        gq   = q_out;
      end
      start     = 1'b0;
      frq_valid = 1'b0;
      if (acc < int'(n)) begin
        case (gap)
          0:       v = 1'b1;
          1:       v = (c % 2) == 1;
          default: v = $urandom_range(0, 1) == 1;
        endcase
        val      = (pat.size() > 0) ? pat[acc % pat.size()] : rnd_fs();
        in_valid = v;
        in_s     = 16'(val);
        if (v) begin
          mi += longint'(val) * nco(ph, 1'b0);
          mq += longint'(val) * nco(ph, 1'b1);
          acc++;
          if (acc == int'(n)) begin
            last_c = c;
            if (poke) begin start = 1'b1; n_samples = 16'd5; end
          end
        end
        if (poke && c == 2) begin
          start     = 1'b1;
          n_samples = 16'd7;
          frq_valid = 1'b1;
          frq       = 32'h1234_5678;
        end
        ph = ph + f;
      end else begin
        in_valid = $urandom_range(0, 1) == 1;
        in_s     = 16'(rnd_fs());
      end
    end
    if (!has_exp) begin
      exp_i = mi;
      exp_q = mq;
    end
    check({name, " out_valid_cycle"}, ov_c, last_c + 5);
    check({name, " busy_errors"}, busy_err, 0);
    check({name, " i_out"}, gi, exp_i);
    check({name, " q_out"}, gq, exp_q);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({name, " single_pulse"}, out_valid, 0);
    check({name, " i_hold"}, i_out, exp_i);
  endtask

  initial begin
    int hits;
    rst_n = 1'b0; frq_valid = 1'b0; start = 1'b0; in_valid = 1'b0;
    frq = '0; phase_offset = '0; n_samples = '0; in_s = '0;

    vecs[0] = '{"dc0",    32'h0,        32'h0,        16'd4, 0, 1000, 1000, 1000, 1000, 1'b1,  131068000, 0};
    vecs[1] = '{"dc90",   32'h0,        32'h4000_0000, 16'd4, 0, 1000, 1000, 1000, 1000, 1'b1, 0,  131068000};
    vecs[2] = '{"dc180",  32'h0,        32'h8000_0000, 16'd4, 0, 1000, 1000, 1000, 1000, 1'b1, -131068000, 0};
    vecs[3] = '{"dc270",  32'h0,        32'hC000_0000, 16'd4, 0, 1000, 1000, 1000, 1000, 1'b1, 0, -131068000};
    vecs[4] = '{"fs4",    32'h4000_0000, 32'h0,        16'd4, 0, 1000, 0, -1000, 0,       1'b1,  65534000, 0};
    vecs[5] = '{"fs4gap", 32'h4000_0000, 32'h0,        16'd4, 1, 1000, 0, -1000, 0,       1'b0,  0, 0};

    #3;
    check("reset busy", busy, 0);
    check("reset out_valid", out_valid, 0);
    check("reset i_out", i_out, 0);
    check("reset q_out", q_out, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      pat = {vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3};
      run_acq(vecs[i].name, vecs[i].f, vecs[i].off, vecs[i].n, vecs[i].gap, 1'b0, 1'b1,
              vecs[i].has_exp, vecs[i].ei, vecs[i].eq);
    end

    pat.delete();
    run_acq("poke", 32'h0B00_0123, 32'h7000_0000, 16'd6, 0, 1'b1, 1'b1, 1'b0, 0, 0);

    start = 1'b1; n_samples = 16'd0;
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy || out_valid) hits++;
    end
    check("nzero activity", hits, 0);

    frq_valid = 1'b1; frq = 32'h0100_0000;
    @(posedge clk); #1;
    frq_valid = 1'b0; start = 1'b1; n_samples = 16'd100; phase_offset = '0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_s = 16'sd500;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst i_out", i_out, 0);
    check("midrst q_out", q_out, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pat = {1};
    run_acq("post_rst", 32'h0, 32'h0, 16'd2, 0, 1'b0, 1'b0, 1'b1, 65534, 0);

    pat.delete();
    for (int r = 0; r < 5; r++)
      run_acq($sformatf("rand%0d", r), $urandom, $urandom, 16'($urandom_range(1, 800)),
              2, 1'b0, 1'b1, 1'b0, 0, 0);
    run_acq("full_n", $urandom, $urandom, 16'hFFFF, 0, 1'b0, 1'b1, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
